// File: rtl/adc_sample_fifo_pkg.sv
// -----------------------------------------------------------------------------
// adc_fifo_pkg
// Shared definitions for the ADC sample FIFO slice.
//   DROP_CNT_W  : width of the saturating dropped-sample counter
//   level_width : occupancy register width for a given depth (0..DEPTH)
//   abs_sat     : saturated magnitude of a sign-extended sample
// -----------------------------------------------------------------------------
package adc_fifo_pkg;

  localparam int DROP_CNT_W = 16;

  // One extra bit so that the value DEPTH itself is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The caller sign-extends its sample to 64 bits and passes its true width.
  // The most negative value has no positive counterpart in 'width' bits, so
  // its magnitude clamps to the largest positive value.
  function automatic logic signed [63:0] abs_sat(input logic signed [63:0] sample,
                                                 input int unsigned       width);
    logic signed [63:0] max_pos;
    logic signed [63:0] mag;
    max_pos = (64'sd1 <<< (width - 1)) - 64'sd1;
    mag     = (sample < 64'sd0) ? -sample : sample;
    return (mag > max_pos) ? max_pos : mag;
  endfunction

endpackage

// File: rtl/adc_sample_fifo_if.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo_if
// Bus between the ADC producer / sample consumer and adc_sample_fifo.
//   Producer side : in_data, in_valid (no backpressure)
//   Consumer side : out_data, out_valid, out_ready
//   Status        : level, almost_full, overflow, drop_cnt, clr_overflow
//   ADC_FIFO_PEAK_EN defined adds peak (out) and peak_clr (in).
// Modports: master = producer/consumer/status owner, slave = the FIFO.
// -----------------------------------------------------------------------------
interface adc_sample_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  import adc_fifo_pkg::*;

  localparam int LVL_W = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      level;
  logic                  almost_full;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  clr_overflow;
`ifdef ADC_FIFO_PEAK_EN
  logic [DATA_WIDTH-1:0] peak;
  logic                  peak_clr;

  modport master (
    output in_data, in_valid, out_ready, clr_overflow, peak_clr,
    input  out_data, out_valid, level, almost_full, overflow, drop_cnt, peak
  );
  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow, peak_clr,
    output out_data, out_valid, level, almost_full, overflow, drop_cnt, peak
  );
`else
  modport master (
    output in_data, in_valid, out_ready, clr_overflow,
    input  out_data, out_valid, level, almost_full, overflow, drop_cnt
  );
  modport slave (
    input  in_data, in_valid, out_ready, clr_overflow,
    output out_data, out_valid, level, almost_full, overflow, drop_cnt
  );
`endif

endinterface

// File: rtl/adc_peak_detect.sv
// -----------------------------------------------------------------------------
// adc_peak_detect
// Tracks the largest saturated magnitude among accepted samples.
//   clk, rst   : clock, asynchronous active-high reset
//   sample     : two's complement sample
//   sample_vld : sample was accepted into the FIFO this cycle
//   clr        : restart tracking; a coincident valid sample becomes the peak
//   peak       : registered running maximum |sample|
// Only instantiated when ADC_FIFO_PEAK_EN is defined.
// -----------------------------------------------------------------------------
module adc_peak_detect
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_vld,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] peak
);

  logic [DATA_WIDTH-1:0] w_mag;
  logic [DATA_WIDTH-1:0] r_peak;

  assign w_mag = DATA_WIDTH'(abs_sat(64'(signed'(sample)), DATA_WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak <= '0;
    end else if (sample_vld) begin
      if (clr || (w_mag > r_peak)) r_peak <= w_mag;
    end else if (clr) begin
      r_peak <= '0;
    end
  end

  assign peak = r_peak;

endmodule

// File: rtl/adc_sample_fifo.sv
// -----------------------------------------------------------------------------
// adc_sample_fifo
// First-word-fall-through elastic buffer behind the sigma-delta decimator.
// Writes never stall: a sample arriving while full (and no read that cycle)
// is dropped, flagged on the sticky overflow bit and counted in drop_cnt.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : adc_sample_fifo_if.slave (see interface for signal list)
// Parameters: DATA_WIDTH, DEPTH (power of 2, >= 2), ALMOST_FULL_LEVEL.
// Macro ADC_FIFO_PEAK_EN adds the peak-magnitude detector.
// -----------------------------------------------------------------------------
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int DEPTH             = 16,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input logic             clk,
  input logic             rst,
  adc_sample_fifo_if.slave bus
);

  localparam int LVL_W = level_width(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [LVL_W-1:0] level_t;
  typedef logic [PTR_W-1:0] ptr_t;

  localparam level_t LVL_FULL = level_t'(DEPTH);
  localparam level_t LVL_AF   = level_t'(ALMOST_FULL_LEVEL);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  ptr_t                  r_wr_ptr;
  ptr_t                  r_rd_ptr;
  level_t                r_level;
  logic                  r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic w_rd;
  logic w_wr;
  logic w_drop;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write when the consumer takes the head.
  assign w_rd   = (r_level != '0) && bus.out_ready;
  assign w_wr   = bus.in_valid && ((r_level != LVL_FULL) || w_rd);
  assign w_drop = bus.in_valid && !w_wr;

  // NOTE: the sample array has no reset; stale entries are never visible
  // because out_data is gated by level, and leaving it out of reset lets it
  // map onto plain RAM/flop arrays without a reset tree.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.in_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      if (w_wr && !w_rd)      r_level <= r_level + level_t'(1);
      else if (w_rd && !w_wr) r_level <= r_level - level_t'(1);
    end
  end

  // A drop in the same cycle as a clear wins: the clear empties the count
  // and this drop becomes its first entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.clr_overflow)   r_drop_cnt <= DROP_CNT_W'(1);
      else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end else if (bus.clr_overflow) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign bus.out_valid   = (r_level != '0);
  assign bus.out_data    = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign bus.level       = r_level;
  assign bus.almost_full = (r_level >= LVL_AF);
  assign bus.overflow    = r_overflow;
  assign bus.drop_cnt    = r_drop_cnt;

`ifdef ADC_FIFO_PEAK_EN
  adc_peak_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_peak (
    .clk        (clk),
    .rst        (rst),
    .sample     (bus.in_data),
    .sample_vld (w_wr),
    .clr        (bus.peak_clr),
    .peak       (bus.peak)
  );
`endif

endmodule
